fpu_align_add: RTL

FPU_ALIGN_ADD -- requirements
Module: fpu_align_add

---
 rtl/fpu_align_add.sv | 118 +++++++++++
 1 files changed

// File: rtl/fpu_align_add.sv
// Purpose: align two IEEE-754 single operands for addition (select larger, shift smaller, track sticky).
// Latency: result valid 2 + min(exponent difference, MAX_SHIFT) cycles after the accept cycle.
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module fpu_align_add #(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  higher_exponent,
  output logic [24:0] frac_large,
  output logic [24:0] frac_small,
  output logic        sticky,
  output logic        sign_large,
  output logic        sign_small,
  output logic        swapped
);

  localparam logic [7:0] MAX_SHIFT_8 = 8'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic [7:0]  cnt;

  logic [7:0]  exp_a, exp_b, eff_a, eff_b, diff, shift_init;
  logic [24:0] fr_a, fr_b;
  logic        b_larger;

  // Decode captured operands and decide ordering and shift amount.
  always_comb begin
    exp_a = a_q[30:23];
    exp_b = b_q[30:23];
    eff_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
    eff_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
    fr_a  = {1'b0, (exp_a != 8'd0), a_q[22:0]};
    fr_b  = {1'b0, (exp_b != 8'd0), b_q[22:0]};
    // Tie-break on the full fraction: when stored exponents match this is the
    // mantissa compare, and it also orders exp=1 above a denormal correctly.
    b_larger   = (eff_b > eff_a) || ((eff_b == eff_a) && (fr_b > fr_a));
    diff       = b_larger ? (eff_b - eff_a) : (eff_a - eff_b);
    shift_init = (diff > MAX_SHIFT_8) ? MAX_SHIFT_8 : diff;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COMPARE;
      end
      COMPARE: state_nxt = (shift_init != 8'd0) ? SHIFT : DONE;
      SHIFT:   if (cnt <= 8'd1) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, select/load, then one-bit-per-cycle right shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q             <= '0;
      b_q             <= '0;
      cnt             <= '0;
      higher_exponent <= '0;
      frac_large      <= '0;
      frac_small      <= '0;
      sticky          <= 1'b0;
      sign_large      <= 1'b0;
      sign_small      <= 1'b0;
      swapped         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= op_a;
            b_q <= op_b;
          end
        end
        COMPARE: begin
          swapped         <= b_larger;
          higher_exponent <= b_larger ? eff_b : eff_a;
          frac_large      <= b_larger ? fr_b : fr_a;
          frac_small      <= b_larger ? fr_a : fr_b;
          sign_large      <= b_larger ? b_q[31] : a_q[31];
          sign_small      <= b_larger ? a_q[31] : b_q[31];
          cnt             <= shift_init;
          sticky          <= 1'b0;
        end
        SHIFT: begin
          frac_small <= frac_small >> 1;
          sticky     <= sticky | frac_small[0];
          cnt        <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
